logic_unit_pipe: RTL and testbench

- Parametrised, registered successor to the team's 6-bit combinational OR unit.
- Width-generic bitwise/shift logic unit with an op select and a one-stage output register.
- Valid/ready handshake on both sides; full throughput under backpressure.
- Persistent flag register (CF/SF/ZF/PF) that downstream branch logic reads. Sits between the operand-fetch stage and writeback in the CPU datapath.

---
 rtl/logic_unit_pkg.sv | 19 +
 rtl/logic_unit_pipe_if.sv | 32 +++
 rtl/logic_unit_core.sv | 47 ++++
 rtl/logic_unit_pipe.sv | 84 ++++++++
 tb/tb_logic_unit_pipe.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - op encodings and flag bit indices for the pipelined logic unit
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_SHR  = 3'd7;

  // Bit positions inside the 4-bit {pf,zf,sf,cf} flag word
  localparam int FLG_CF = 0;
  localparam int FLG_SF = 1;
  localparam int FLG_ZF = 2;
  localparam int FLG_PF = 3;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// rtl/logic_unit_pipe_if.sv - operand/result handshake bundle for the pipelined logic unit
interface logic_unit_pipe_if #(
  parameter int WIDTH = 6
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             upd_flags;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             cf;
  logic             sf;
  logic             zf;
  logic             pf;
  logic [3:0]       flags_q;

  modport master (
    output in_valid, op, a, b, upd_flags, out_ready,
    input  in_ready, out_valid, r, cf, sf, zf, pf, flags_q
  );

  modport slave (
    input  in_valid, op, a, b, upd_flags, out_ready,
    output in_ready, out_valid, r, cf, sf, zf, pf, flags_q
  );

endinterface

// File: rtl/logic_unit_core.sv
// rtl/logic_unit_core.sv - combinational bitwise/shift function with result flags
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] r,
  output logic             cf,
  output logic             sf,
  output logic             zf,
  output logic             pf
);

  always_comb begin
    r  = '0;
    cf = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      // Shifts report the bit pushed out through cf
      OP_SHL: begin
        r  = {a[WIDTH-2:0], 1'b0};
        cf = a[WIDTH-1];
      end
      OP_SHR: begin
        r  = {1'b0, a[WIDTH-1:1]};
        cf = a[0];
      end
      default: begin
        r  = '0;
        cf = 1'b0;
      end
    endcase
  end

  assign sf = r[WIDTH-1];
  assign zf = (r == '0);
  assign pf = ~^r;

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered logic unit with valid/ready handshake and persistent flags
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int         WIDTH      = 6,
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input logic              clk,
  input logic              rst,
  logic_unit_pipe_if.slave bus
);

  logic [WIDTH-1:0] core_r;
  logic             core_cf;
  logic             core_sf;
  logic             core_zf;
  logic             core_pf;
  logic [3:0]       core_flags;

  logic             in_ready;
  logic             accept;
  logic             out_valid_q;
  logic [WIDTH-1:0] r_q;
  logic [3:0]       rflags_q;
  logic [3:0]       flags_q;

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a  (bus.a),
    .b  (bus.b),
    .op (bus.op),
    .r  (core_r),
    .cf (core_cf),
    .sf (core_sf),
    .zf (core_zf),
    .pf (core_pf)
  );

  always_comb begin
    core_flags         = 4'b0000;
    core_flags[FLG_CF] = core_cf;
    core_flags[FLG_SF] = core_sf;
    core_flags[FLG_ZF] = core_zf;
    core_flags[FLG_PF] = core_pf;
  end

  // A consumed result frees the register in the same cycle, so streaming has no bubble
  assign in_ready = ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
      rflags_q    <= 4'b0000;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      r_q         <= core_r;
      rflags_q    <= core_flags;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Branch logic sees flags as soon as the beat is accepted, independent of the consumer
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= FLAG_RESET;
    end else if (accept && bus.upd_flags) begin
      flags_q <= core_flags;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.r         = r_q;
  assign bus.cf        = rflags_q[FLG_CF];
  assign bus.sf        = rflags_q[FLG_SF];
  assign bus.zf        = rflags_q[FLG_ZF];
  assign bus.pf        = rflags_q[FLG_PF];
  assign bus.flags_q   = flags_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - self-checking bench for logic_unit_pipe
module tb_logic_unit_pipe;

  typedef struct packed {
    logic        pf;
    logic        zf;
    logic        sf;
    logic        cf;
    logic [31:0] r;
  } res_t;

  localparam logic [3:0] FR6 = 4'b0101;
  localparam logic [3:0] FR8 = 4'b0011;

  logic clk;
  logic rst;

  logic_unit_pipe_if #(.WIDTH(6)) bus6 ();
  logic_unit_pipe_if #(.WIDTH(8)) bus8 ();

  logic_unit_pipe #(.WIDTH(6), .FLAG_RESET(FR6)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  logic_unit_pipe #(.WIDTH(8), .FLAG_RESET(FR8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_push   = 0;
  int   n_pop    = 0;
  bit   check_en8 = 1'b0;
  bit   sb_rdy;
  res_t sb_new;
  logic [3:0] exp_fq8 = FR8;
  res_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input int op, input int a, input int b, input int w);
    res_t o;
    int   mask;
    int   r;
    mask = (1 << w) - 1;
    o    = '0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: r = a ^ b;
      3: r = ~a;
      4: r = ~(a & b);
      5: r = ~(a | b);
      6: begin r = a << 1; o.cf = ((a >> (w - 1)) & 1) != 0; end
      7: begin r = a >> 1; o.cf = (a & 1) != 0; end
      default: r = 0;
    endcase
    r    = r & mask;
    o.r  = r;
    o.sf = ((r >> (w - 1)) & 1) != 0;
    o.zf = (r == 0);
    o.pf = ($countones(r) % 2) == 0;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk6(input string tag, input logic ev, input logic [5:0] er,
                      input logic [3:0] ef, input logic [3:0] efq);
    chk({tag, "_out_valid"}, 32'(bus6.out_valid), 32'(ev));
    chk({tag, "_r"}, 32'(bus6.r), 32'(er));
    chk({tag, "_flags"}, 32'({bus6.pf, bus6.zf, bus6.sf, bus6.cf}), 32'(ef));
    chk({tag, "_flags_q"}, 32'(bus6.flags_q), 32'(efq));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat6(input logic [2:0] op, input logic [5:0] a, input logic [5:0] b,
                       input logic upd);
    bus6.in_valid  = 1'b1;
    bus6.op        = op;
    bus6.a         = a;
    bus6.b         = b;
    bus6.upd_flags = upd;
  endtask

  // Scoreboard: results produced but not yet consumed, updated at each active edge
  always @(posedge clk) begin
    if (check_en8) begin
      sb_rdy = (sb.size() == 0) || bus8.out_ready;
      if (sb.size() != 0 && bus8.out_ready) begin
        void'(sb.pop_front());
        n_pop++;
      end
      if (bus8.in_valid && sb_rdy) begin
        sb_new = model(int'(bus8.op), int'(bus8.a), int'(bus8.b), 8);
        sb.push_back(sb_new);
        n_push++;
        if (bus8.upd_flags) exp_fq8 = {sb_new.pf, sb_new.zf, sb_new.sf, sb_new.cf};
      end
    end
  end

  always @(negedge clk) begin
    if (check_en8) begin
      chk("s_out_valid", 32'(bus8.out_valid), 32'(sb.size() != 0));
      chk("s_in_ready", 32'(bus8.in_ready), 32'((sb.size() == 0) || bus8.out_ready));
      chk("s_flags_q", 32'(bus8.flags_q), 32'(exp_fq8));
      if (sb.size() != 0) begin
        chk("s_r", 32'(bus8.r), sb[0].r);
        chk("s_flags", 32'({bus8.pf, bus8.zf, bus8.sf, bus8.cf}),
            32'({sb[0].pf, sb[0].zf, sb[0].sf, sb[0].cf}));
      end
    end
  end

  initial begin
    res_t m;
    int   cyc;

    rst = 1'b1;
    bus6.in_valid = 1'b0; bus6.op = 3'd0; bus6.a = '0; bus6.b = '0;
    bus6.upd_flags = 1'b0; bus6.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.op = 3'd0; bus8.a = '0; bus8.b = '0;
    bus8.upd_flags = 1'b0; bus8.out_ready = 1'b0;

    m = model(1, 'b101000, 'b000011, 6);
    chk("model_or", {m.pf, m.zf, m.sf, m.cf, m.r[27:0]}, {4'b1010, 28'h2b});
    m = model(6, 'b100001, 0, 6);
    chk("model_shl", {m.pf, m.zf, m.sf, m.cf, m.r[27:0]}, {4'b0001, 28'h02});
    m = model(7, 'b000001, 0, 6);
    chk("model_shr", {m.pf, m.zf, m.sf, m.cf, m.r[27:0]}, {4'b1101, 28'h00});
    m = model(3, 'h5a, 0, 8);
    chk("model_not8", {m.pf, m.zf, m.sf, m.cf, m.r[27:0]}, {4'b1010, 28'ha5});

    step();
    step();
    chk6("reset6", 1'b0, 6'b000000, 4'b0000, FR6);
    chk("reset8_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("reset8_flags_q", 32'(bus8.flags_q), 32'(FR8));
    rst = 1'b0;

    bus6.out_ready = 1'b1;
    beat6(3'd1, 6'b101000, 6'b000011, 1'b1);
    step();
    chk6("or", 1'b1, 6'b101011, 4'b1010, 4'b1010);
    beat6(3'd0, 6'b101010, 6'b010101, 1'b0);
    step();
    chk6("and", 1'b1, 6'b000000, 4'b1100, 4'b1010);
    beat6(3'd6, 6'b100001, 6'b111111, 1'b1);
    step();
    chk6("shl", 1'b1, 6'b000010, 4'b0001, 4'b0001);
    beat6(3'd7, 6'b000001, 6'b101010, 1'b0);
    step();
    chk6("shr", 1'b1, 6'b000000, 4'b1101, 4'b0001);
    bus6.in_valid = 1'b0;
    step();
    chk("drain_out_valid", 32'(bus6.out_valid), 32'd0);

    bus6.out_ready = 1'b0;
    beat6(3'd2, 6'b110011, 6'b010101, 1'b0);
    #1;
    chk("bp_ready_empty", 32'(bus6.in_ready), 32'd1);
    step();
    chk6("bp_first", 1'b1, 6'b100110, 4'b0010, 4'b0001);
    beat6(3'd5, 6'b000011, 6'b000100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", 32'(bus6.in_ready), 32'd0);
      step();
      chk6("bp_hold", 1'b1, 6'b100110, 4'b0010, 4'b0001);
    end
    bus6.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus6.in_ready), 32'd1);
    step();
    chk6("bp_second", 1'b1, 6'b111000, 4'b0010, 4'b0001);
    beat6(3'd4, 6'b111111, 6'b111111, 1'b1);
    step();
    chk6("bp_third", 1'b1, 6'b000000, 4'b1100, 4'b1100);
    bus6.in_valid = 1'b0;
    step();
    chk("bp_drained", 32'(bus6.out_valid), 32'd0);

    bus6.out_ready = 1'b0;
    beat6(3'd3, 6'b000000, 6'b000000, 1'b1);
    step();
    chk6("stall", 1'b1, 6'b111111, 4'b1010, 4'b1010);
    step();
    chk6("stall_hold", 1'b1, 6'b111111, 4'b1010, 4'b1010);
    beat6(3'd1, 6'b000001, 6'b000010, 1'b1);
    bus6.out_ready = 1'b1;
    rst = 1'b1;
    step();
    chk6("mid_reset", 1'b0, 6'b000000, 4'b0000, FR6);
    rst = 1'b0;
    bus6.in_valid = 1'b0;
    step();
    chk6("post_reset", 1'b0, 6'b000000, 4'b0000, FR6);

    check_en8 = 1'b1;
    cyc = 0;
    while (n_push < 32 && cyc < 2000) begin
      bus8.in_valid  = ($urandom_range(3) != 0);
      bus8.op        = 3'($urandom_range(7));
      bus8.a         = 8'($urandom);
      bus8.b         = 8'($urandom);
      bus8.upd_flags = ($urandom_range(1) != 0);
      bus8.out_ready = ($urandom_range(2) != 0);
      step();
      cyc++;
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    repeat (3) step();
    chk("stream_accepted", 32'(n_push), 32'd32);
    chk("stream_consumed", 32'(n_pop), 32'd32);
    check_en8 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
